alu_instr_encoder: RTL

//   Inverse of the ALU decode path: takes an ALU operation request (aluControl code, registers, optional

---
 rtl/alu_instr_encoder_pkg.sv | 43 ++++
 rtl/alu_instr_encoder_rv_field_pack.sv | 27 ++
 rtl/alu_instr_encoder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/alu_instr_encoder_pkg.sv
// Shared ALU-control codes and RV32I field constants.
// The ALU decoder imports the same package, so encoder and decoder stay consistent.
package alu_instr_encoder_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_U = 2'd2
  } fmt_e;

  function automatic logic alu_legal(input logic [2:0] alu);
    return (alu == ALU_ADD) || (alu == ALU_SUB) || (alu == ALU_AND) ||
           (alu == ALU_OR)  || (alu == ALU_SLT);
  endfunction

  function automatic logic [2:0] alu_f3(input logic [2:0] alu);
    case (alu)
      ALU_AND: return F3_AND;
      ALU_OR:  return F3_OR;
      ALU_SLT: return F3_SLT;
      default: return F3_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_instr_encoder_rv_field_pack.sv
// Combinational RV32I word assembly for R, I and U formats.
// For U format the upper 20 bits of imm are placed directly; the caller pre-rounds them.
module rv_field_pack
  import alu_instr_encoder_pkg::*;
(
  input  fmt_e        fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  f3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [6:0]  f7,
  input  logic [31:0] imm,
  output logic [31:0] word
);

  always_comb begin
    word = 32'd0;
    case (fmt)
      FMT_R:   word = {f7, rs2, rs1, f3, rd, opcode};
      FMT_I:   word = {imm[11:0], rs1, f3, rd, opcode};
      FMT_U:   word = {imm[31:12], rd, opcode};
      default: word = 32'd0;
    endcase
  end

endmodule

// File: rtl/alu_instr_encoder.sv
// Turns an ALU operation request into one RV32I word, or a LUI/ADDI/R-type triple
// when the immediate does not fit in 12 bits, streamed with incrementing byte addresses.
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// EMIT   | single R/I-type word presented
// LUI    | expansion word 1: LUI TMP_REG,hi
// ADDI   | expansion word 2: ADDI TMP_REG,TMP_REG,lo
// OP     | expansion word 3: R-type op rd,rs1,TMP_REG
module alu_instr_encoder
  import alu_instr_encoder_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter logic [4:0]  TMP_REG = 5'd31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_alu,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic              req_use_imm,
  input  logic [31:0]       req_imm,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              err,
  output logic [15:0]       word_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EMIT = 3'd1,
    S_LUI  = 3'd2,
    S_ADDI = 3'd3,
    S_OP   = 3'd4
  } state_e;

  state_e state, state_next;

  logic [4:0]  lat_rd, lat_rs1;
  logic [2:0]  lat_f3;
  logic [31:0] lat_immp;

  logic        accept, consumed, word_load;
  logic        req_legal, req_fits;
  logic [2:0]  req_f3;
  logic [31:0] req_immp;

  fmt_e        pk_fmt;
  logic [6:0]  pk_op, pk_f7;
  logic [4:0]  pk_rd, pk_rs1, pk_rs2;
  logic [2:0]  pk_f3;
  logic [31:0] pk_imm, pk_word;

  assign accept    = req_valid & req_ready;
  assign consumed  = instr_valid & instr_ready;
  assign req_legal = alu_legal(req_alu);
  assign req_f3    = alu_f3(req_alu);
  // An immediate subtract is an add of the negated immediate.
  assign req_immp  = (req_alu == ALU_SUB) ? (32'd0 - req_imm) : req_imm;
  assign req_fits  = (req_immp[31:11] == '0) || (req_immp[31:11] == '1);

  rv_field_pack u_pack (
    .fmt    (pk_fmt),
    .opcode (pk_op),
    .rd     (pk_rd),
    .f3     (pk_f3),
    .rs1    (pk_rs1),
    .rs2    (pk_rs2),
    .f7     (pk_f7),
    .imm    (pk_imm),
    .word   (pk_word)
  );

  always_comb begin
    state_next = state;
    word_load  = 1'b0;
    pk_fmt     = FMT_R;
    pk_op      = OP_R;
    pk_rd      = req_rd;
    pk_f3      = req_f3;
    pk_rs1     = req_rs1;
    pk_rs2     = req_rs2;
    pk_f7      = F7_BASE;
    pk_imm     = req_immp;
    case (state)
      S_IDLE: begin
        if (accept && req_legal) begin
          word_load = 1'b1;
          if (!req_use_imm) begin
            pk_f7      = (req_alu == ALU_SUB) ? F7_SUB : F7_BASE;
            state_next = S_EMIT;
          end else if (req_fits) begin
            pk_fmt     = FMT_I;
            pk_op      = OP_I;
            state_next = S_EMIT;
          end else begin
            // Rounding by 0x800 compensates for the sign-extended low 12 bits.
            pk_fmt     = FMT_U;
            pk_op      = OP_LUI;
            pk_rd      = TMP_REG;
            pk_imm     = req_immp + 32'h0000_0800;
            state_next = S_LUI;
          end
        end
      end
      S_EMIT: if (consumed) state_next = S_IDLE;
      S_LUI: begin
        if (consumed) begin
          word_load  = 1'b1;
          pk_fmt     = FMT_I;
          pk_op      = OP_I;
          pk_rd      = TMP_REG;
          pk_rs1     = TMP_REG;
          pk_f3      = F3_ADD;
          pk_imm     = lat_immp;
          state_next = S_ADDI;
        end
      end
      S_ADDI: begin
        if (consumed) begin
          word_load  = 1'b1;
          pk_rd      = lat_rd;
          pk_rs1     = lat_rs1;
          pk_rs2     = TMP_REG;
          pk_f3      = lat_f3;
          state_next = S_OP;
        end
      end
      S_OP:    if (consumed) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      req_ready   <= 1'b1;
      instr_valid <= 1'b0;
      instr       <= 32'd0;
      instr_addr  <= '0;
      err         <= 1'b0;
      word_count  <= 16'd0;
      lat_rd      <= 5'd0;
      lat_rs1     <= 5'd0;
      lat_f3      <= 3'd0;
      lat_immp    <= 32'd0;
    end else begin
      state     <= state_next;
      req_ready <= (state_next == S_IDLE);
      err       <= accept & ~req_legal;
      if (word_load) begin
        instr_valid <= 1'b1;
        instr       <= pk_word;
      end else if (consumed) begin
        instr_valid <= 1'b0;
      end
      if (state == S_IDLE && base_load)
        instr_addr <= base_addr & ~ADDR_W'(3);
      else if (consumed)
        instr_addr <= instr_addr + ADDR_W'(4);
      if (consumed)
        word_count <= word_count + 16'd1;
      if (accept) begin
        lat_rd   <= req_rd;
        lat_rs1  <= req_rs1;
        lat_f3   <= req_f3;
        lat_immp <= req_immp;
      end
    end
  end

endmodule
